// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and
// buffer occupancy states.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender. BRANCH shift only exists when
// IMM_EXT_BRANCH_EN is defined; otherwise mode 3 falls through to SIGN.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  imm_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
    case (mode)
      MODE_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, data};
      MODE_UPPER:  ext = {data, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
      MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
`endif
      default:     ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid buffer (main + skid register).
// Optional BRANCH mode enabled by macro IMM_EXT_BRANCH_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic [1:0]       occ_o
);

  occ_state_t       state_q, state_d;
  logic [OUT_W-1:0] main_q, main_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic [OUT_W-1:0] ext_w;
  logic             ready_q;
  logic             accept;
  logic             xfer;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .data(data_i),
    .mode(imm_mode_t'(mode_i)),
    .ext (ext_w)
  );

  assign accept  = valid_i && ready_q && !flush_i;
  assign valid_o = (state_q != OCC_EMPTY);
  assign xfer    = valid_o && ready_i;
  assign ready_o = ready_q;
  assign data_o  = main_q;
  assign occ_o   = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d  = ext_w;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && xfer) begin
            main_d = ext_w;
          end else if (accept) begin
            skid_d  = ext_w;
            state_d = OCC_FULL;
          end else if (xfer) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // ready_o is low here, so only the skid-to-main shift can happen
          if (xfer) begin
            main_d  = skid_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != OCC_FULL);
    end
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, the immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, the extended output width in bits; OUT_W >= IN_W+2 is legal, smaller values are a configuration error.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have port flush_i, input, 1, which discards all buffered entries.
REQ-006 The block SHALL have port valid_i, input, 1, meaning the upstream data is valid.
REQ-007 The block SHALL have port ready_o, output, 1, meaning the block can accept data this cycle.
REQ-008 The block SHALL have port data_i, input, IN_W, the raw immediate.
REQ-009 The block SHALL have port mode_i, input, 2, the extension mode (SIGN=0, ZERO=1, UPPER=2, BRANCH=3).
REQ-010 The block SHALL have port valid_o, output, 1, meaning data_o is valid.
REQ-011 The block SHALL have port ready_i, input, 1, meaning downstream accepts data_o.
REQ-012 The block SHALL have port data_o, output, OUT_W, the extended result.
REQ-013 The block SHALL have port occ_o, output, 2, the current entry count (0..2).

Function
REQ-014 SIGN mode SHALL replicate data_i[IN_W-1] into bits OUT_W-1..IN_W.
REQ-015 ZERO mode SHALL fill bits OUT_W-1..IN_W with 0.
REQ-016 UPPER mode SHALL place data_i in bits OUT_W-1..OUT_W-IN_W and zero the remaining low bits.
REQ-017 BRANCH mode SHALL sign-extend data_i and shift the result left by 2, with the two LSBs 0 and overflow bits discarded at OUT_W.
REQ-018 The mode SHALL be sampled together with data_i on acceptance; the result is computed at capture and stored extended.
REQ-019 Acceptance SHALL occur when valid_i && ready_o; output transfer SHALL occur when valid_o && ready_i.
REQ-020 Storage SHALL be a 2-entry skid buffer (main output register plus skid register); ready_o = (occ_o < 2), registered, with no combinational path from ready_i.
REQ-021 Latency SHALL be 1 cycle: data accepted at edge N is visible on data_o with valid_o=1 after edge N when the buffer was empty.
REQ-022 Ordering SHALL be FIFO; on an output transfer the skid entry moves to the main register in the same edge.
REQ-023 Simultaneous accept and transfer SHALL leave occ_o unchanged; at occ_o=2 with a transfer, ready_o returns to 1 the next cycle.
REQ-024 data_o SHALL be held stable while valid_o=1 and ready_i=0.
REQ-025 flush_i=1 SHALL empty both entries at the edge (occ_o=0, valid_o=0) and SHALL block acceptance in that cycle; flush takes priority over accept and transfer.

Reset
REQ-026 When rst_i=1 at an edge, the block SHALL set occ_o=0, valid_o=0, ready_o=1, and data_o=0, and SHALL discard in-flight entries; rst_i has priority over flush_i.
REQ-027 Reset asserted mid-transfer SHALL lose the entry without a partial output.

Configuration
REQ-028 Macro IMM_EXT_BRANCH_EN SHALL control BRANCH mode: when defined, mode 3 behaves as in REQ-017; when undefined, mode 3 behaves exactly as SIGN and no shift logic is synthesised.

Structure
REQ-029 Package imm_ext_pkg SHALL hold the mode encoding typedef (imm_mode_t) and the mode constants.
REQ-030 The extension logic SHALL be a combinational sub-module imm_ext_core (data, mode in; extended word out), instantiated once at the buffer input.

Verification
REQ-031 SIGN, data_i=16'h8004, single accept with ready_i=1 -> data_o=32'hFFFF8004 one cycle later; ZERO gives 32'h00008004.
REQ-032 UPPER data_i=16'h1234 -> 32'h12340000; BRANCH data_i=16'hFFFF -> 32'hFFFFFFFC with macro defined, 32'hFFFFFFFF without it.
REQ-033 Hold ready_i=0 and accept 3 words -> occ_o=2, ready_o=0, third word not taken; release ready_i -> words emerge in order, one per cycle.
REQ-034 At occ_o=1, accept and transfer in the same cycle -> occ_o stays 1 and the next word follows on data_o.
REQ-035 At occ_o=2, assert flush_i with valid_i=1 -> occ_o=0, valid_o=0, input not accepted; rst_i mid-stream -> all outputs at reset values next cycle.
